pll_lock_supervisor: RTL and testbench

//  Drives the reset input of a PLL and consumes its locked output: pulses the PLL reset, waits for lock with timeout and retry,

---
 rtl/pll_sup_pkg.sv | 21 ++
 rtl/pll_sup_sync.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 125 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    // Width of the shared phase counter: it only ever needs to reach (largest length - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Multi-flop synchronizer for a single asynchronous level; chain clears to 0 on reset.
module pll_sup_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for stable lock with timeout and retry, then releases sys_rst.
// Define PLL_SUP_AUTO_RELOCK_EN to restart the lock sequence on lock loss in RUN instead of latching a failure.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_ok,
    output logic       fail,
    output logic [3:0] retry_count
);

    localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic          locked_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          lock_ok_q, lock_ok_d;
    logic          fail_q, fail_d;

    pll_sup_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            lock_ok_q <= lock_ok_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle still wins.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = FAIL;
                    end else begin
                        state_d = RESET_PLL;
                        if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
                    end
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
`ifdef PLL_SUP_AUTO_RELOCK_EN
                    state_d = RESET_PLL;
`else
                    state_d = FAIL;
`endif
                end
            end
            FAIL:    state_d = FAIL;
            default: state_d = FAIL;
        endcase

        if (state_d == RUN) retry_d = '0;
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_comb begin
        pll_rst_d = (state_d == RESET_PLL) || (state_d == FAIL);
        sys_rst_d = (state_d != RUN);
        lock_ok_d = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign lock_ok     = lock_ok_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized bench for pll_lock_supervisor: deadline-based reference model feeding a per-cycle scoreboard.
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int ST = 8;
    localparam int MR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, lock_ok, fail;
    logic [3:0] retry_count;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR),
        .SYNC_STAGES         (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .lock_ok     (lock_ok),
        .fail        (fail),
        .retry_count (retry_count)
    );

    always #5 refclk = ~refclk;

    // Reference model: phases with absolute deadlines (edge numbers), lock seen through a 2-edge delay line.
    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_DEAD  = 4;

    int         ph;
    int         edge_no;
    int         deadline;
    int         tries;
    bit         lag[$];
    logic [7:0] sb[$];
    int         n_tests = 0;
    int         n_fail = 0;

    function automatic void model_reset();
        ph       = PH_PULSE;
        edge_no  = 0;
        deadline = RP;
        tries    = 0;
        lag.delete();
        for (int i = 0; i < 2; i++) lag.push_back(1'b0);
    endfunction

    function automatic void enter(input int p, input int len);
        ph       = p;
        deadline = edge_no + len;
    endfunction

    function automatic void model_edge();
        bit ls;
        if (rst) begin
            model_reset();
        end else begin
            edge_no++;
            ls = lag.pop_front();
            lag.push_back(pll_locked);
            case (ph)
                PH_PULSE: if (edge_no == deadline) enter(PH_WAIT, TO);
                PH_WAIT: begin
                    if (ls) enter(PH_HOLD, ST);
                    else if (edge_no == deadline) begin
                        if (tries >= MR) enter(PH_DEAD, 0);
                        else begin
                            tries++;
                            enter(PH_PULSE, RP);
                        end
                    end
                end
                PH_HOLD: begin
                    if (!ls) enter(PH_WAIT, TO);
                    else if (edge_no == deadline) enter(PH_RUN, 0);
                end
                PH_RUN: begin
                    if (!ls) begin
`ifdef PLL_SUP_AUTO_RELOCK_EN
                        enter(PH_PULSE, RP);
`else
                        enter(PH_DEAD, 0);
`endif
                    end
                end
                default: ;
            endcase
            if (ph == PH_RUN) tries = 0;
        end
    endfunction

    function automatic logic [7:0] expect_vec();
        return {(ph == PH_PULSE) || (ph == PH_DEAD), ph != PH_RUN, ph == PH_RUN,
                ph == PH_DEAD, 4'(tries)};
    endfunction

    // One edge: model the edge, queue the expected outputs, then set the level for the next edge.
    task automatic step(input bit lvl);
        @(posedge refclk);
        model_edge();
        sb.push_back(expect_vec());
        #2 pll_locked = lvl;
    endtask

    task automatic run(input bit lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    // Asserted mid-cycle: the next negedge sample must already show reset values.
    task automatic pulse_rst();
        rst = 1'b1;
        model_reset();
        void'(sb.pop_back());
        sb.push_back(expect_vec());
        step(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        forever begin
            @(negedge refclk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act_v = {pll_rst, sys_rst, lock_ok, fail, retry_count};
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t {pll_rst,sys_rst,lock_ok,fail,retry} got=%b want=%b",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        model_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        run(1'b0, 3);
        rst = 1'b0;

        // Clean lock, then loss in RUN.
        run(1'b0, 8);
        run(1'b1, 30);
        run(1'b0, 12);
        pulse_rst();

        // No lock at all: all retries exhausted, failure holds.
        run(1'b0, 3 * (RP + TO) + 15);
        pulse_rst();

        // One-cycle glitch during the stable window.
        run(1'b0, 8);
        run(1'b1, 5);
        run(1'b0, 1);
        run(1'b1, 25);
        pulse_rst();

        // Reset lands in the second wait window (retry_count=1).
        run(1'b0, 30);
        pulse_rst();

        // Lock reaches the FSM exactly on the timeout edge.
        run(1'b0, 20);
        run(1'b1, 20);
        pulse_rst();

        // Lock one cycle too late: timeout wins, second attempt then locks.
        run(1'b0, 21);
        run(1'b1, 40);
        run(1'b0, 10);
        pulse_rst();

        // Random lock waveform with occasional resets.
        for (int s = 0; s < 60; s++) begin
            run(1'($urandom_range(0, 1)), $urandom_range(1, 30));
            if ($urandom_range(0, 9) == 0) pulse_rst();
        end

        repeat (3) @(negedge refclk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
